// File: rtl/fir_coeff_load_ctrl.sv
// rtl/fir_coeff_load_ctrl.sv - FIR coefficient reload sequencer: load, flush, then qualify FIR output.
// Optional macro FIR_CTRL_TIMEOUT_EN adds a 1024-cycle LOAD stall timeout.
module fir_coeff_load_ctrl #(
    parameter int N           = 37,
    parameter int COEFF_WIDTH = 16,
    parameter int LAT         = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_start,
    input  logic                   cfg_valid,
    input  logic [COEFF_WIDTH-1:0] cfg_data,
    input  logic                   cfg_last,
    output logic                   cfg_ready,
    output logic                   coef_we,
    output logic [5:0]             coef_addr,
    output logic [COEFF_WIDTH-1:0] coef_wdata,
    output logic                   fir_zero_in,
    output logic                   y_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int CW = $clog2(N + LAT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   err_nxt, we_nxt, done_nxt;
    logic [5:0]             addr_nxt;
    logic [COEFF_WIDTH-1:0] wdata_nxt;
    logic                   beat;
    logic [LAT-1:0]         vsr;
`ifdef FIR_CTRL_TIMEOUT_EN
    logic [9:0]             tmo, tmo_nxt;
`endif

    assign cfg_ready   = (state == LOAD);
    assign busy        = (state == LOAD) || (state == FLUSH);
    assign fir_zero_in = (state != RUN);
    assign beat        = (state == LOAD) && cfg_valid;
    assign y_valid     = vsr[LAT-1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err;
        we_nxt    = 1'b0;
        addr_nxt  = coef_addr;
        wdata_nxt = coef_wdata;
        done_nxt  = 1'b0;
`ifdef FIR_CTRL_TIMEOUT_EN
        tmo_nxt   = tmo;
`endif
        case (state)
            IDLE, RUN: begin
                if (cfg_start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
`ifdef FIR_CTRL_TIMEOUT_EN
                    tmo_nxt   = '0;
`endif
                end
            end
            LOAD: begin
                if (beat) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = 6'(cnt);
                    wdata_nxt = cfg_data;
`ifdef FIR_CTRL_TIMEOUT_EN
                    tmo_nxt   = '0;
`endif
                    // Only a last beat landing exactly on the final tap is a clean load.
                    if (cnt == CW'(N - 1) && cfg_last) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = '0;
                    end else if (cnt == CW'(N - 1) || cfg_last) begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
`ifdef FIR_CTRL_TIMEOUT_EN
                else if (tmo == 10'd1023) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    tmo_nxt = tmo + 1'b1;
                end
`endif
            end
            FLUSH: begin
                if (cnt == CW'(N + LAT - 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset lands in FLUSH: the bank holds power-up coefficients, the delay line does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FLUSH;
            cnt        <= '0;
            err        <= 1'b0;
            coef_we    <= 1'b0;
            coef_addr  <= '0;
            coef_wdata <= '0;
            done       <= 1'b0;
`ifdef FIR_CTRL_TIMEOUT_EN
            tmo        <= '0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            err        <= err_nxt;
            coef_we    <= we_nxt;
            coef_addr  <= addr_nxt;
            coef_wdata <= wdata_nxt;
            done       <= done_nxt;
`ifdef FIR_CTRL_TIMEOUT_EN
            tmo        <= tmo_nxt;
`endif
        end
    end

    // Mirrors the FIR pipeline: samples fed in RUN emerge LAT cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsr <= '0;
        end else if (state == RUN && state_nxt != RUN) begin
            vsr <= '0;
        end else begin
            vsr <= (vsr << 1) | LAT'(state == RUN);
        end
    end

endmodule

// File: tb/tb_fir_coeff_load_ctrl.sv
// tb/tb_fir_coeff_load_ctrl.sv - self-checking bench for fir_coeff_load_ctrl against a behavioural model.
module tb_fir_coeff_load_ctrl;
    localparam int N   = 37;
    localparam int CWD = 16;
    localparam int LAT = 9;
    localparam int M_IDLE = 0, M_LOAD = 1, M_FLUSH = 2, M_RUN = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_start = 1'b0;
    logic           cfg_valid = 1'b0;
    logic [CWD-1:0] cfg_data = '0;
    logic           cfg_last = 1'b0;
    logic           cfg_ready, coef_we, fir_zero_in, y_valid, busy, done, err;
    logic [5:0]     coef_addr;
    logic [CWD-1:0] coef_wdata;

    fir_coeff_load_ctrl #(.N(N), .COEFF_WIDTH(CWD), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_data(cfg_data), .cfg_last(cfg_last), .cfg_ready(cfg_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .fir_zero_in(fir_zero_in), .y_valid(y_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int we_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: mode plus time-in-mode; y_valid follows from how long RUN has lasted.
    int  m_mode = M_FLUSH, m_cnt = 0, m_age = 0, m_addr = 0, m_wdata = 0;
    bit  m_err = 1'b0, m_we = 1'b0;
`ifdef FIR_CTRL_TIMEOUT_EN
    int  m_tmo = 0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_FLUSH; m_cnt = 0; m_age = 0; m_err = 1'b0;
            m_we = 1'b0; m_addr = 0; m_wdata = 0;
`ifdef FIR_CTRL_TIMEOUT_EN
            m_tmo = 0;
`endif
        end else begin
            m_we = 1'b0;
            case (m_mode)
                M_IDLE, M_RUN: begin
                    if (cfg_start) begin
                        m_mode = M_LOAD; m_cnt = 0; m_err = 1'b0;
`ifdef FIR_CTRL_TIMEOUT_EN
                        m_tmo = 0;
`endif
                    end else if (m_mode == M_RUN) m_age++;
                end
                M_LOAD: begin
                    if (cfg_valid) begin
                        m_we = 1'b1; m_addr = m_cnt; m_wdata = int'(cfg_data);
`ifdef FIR_CTRL_TIMEOUT_EN
                        m_tmo = 0;
`endif
                        if (m_cnt == N - 1 && cfg_last) begin
                            m_mode = M_FLUSH; m_cnt = 0;
                        end else if (m_cnt == N - 1 || cfg_last) begin
                            m_mode = M_IDLE; m_err = 1'b1;
                        end else m_cnt++;
                    end
`ifdef FIR_CTRL_TIMEOUT_EN
                    else begin
                        m_tmo++;
                        if (m_tmo == 1024) begin m_mode = M_IDLE; m_err = 1'b1; end
                    end
`endif
                end
                default: begin
                    m_cnt++;
                    if (m_cnt == N + LAT) begin m_mode = M_RUN; m_age = 0; m_cnt = 0; end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (coef_we === 1'b1) we_cnt++;
        if (chk_en) begin
            chk("cfg_ready", 32'(cfg_ready), 32'(m_mode == M_LOAD));
            chk("busy", 32'(busy), 32'(m_mode == M_LOAD || m_mode == M_FLUSH));
            chk("fir_zero_in", 32'(fir_zero_in), 32'(m_mode != M_RUN));
            chk("done", 32'(done), 32'(m_mode == M_RUN && m_age == 0));
            chk("y_valid", 32'(y_valid), 32'(m_mode == M_RUN && m_age >= LAT));
            chk("err", 32'(err), 32'(m_err));
            chk("coef_we", 32'(coef_we), 32'(m_we));
            if (m_we) begin
                chk("coef_addr", 32'(coef_addr), 32'(m_addr));
                chk("coef_wdata", 32'(coef_wdata), 32'(m_wdata));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic send(input int nb, input int last_idx, input bit gaps);
        for (int i = 0; i < nb; i++) begin
            if (gaps) while ($urandom_range(0, 2) == 0) step();
            cfg_valid = 1'b1;
            cfg_data  = CWD'($urandom);
            cfg_last  = (i == last_idx);
            step();
            cfg_valid = 1'b0;
            cfg_last  = 1'b0;
        end
    endtask

    // Cycle index of first done and first y_valid, -1 if not seen within limit.
    task automatic measure(output int td, output int ty, input int limit);
        td = -1; ty = -1;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (done === 1'b1 && td < 0) td = c;
            if (y_valid === 1'b1 && ty < 0) ty = c;
            if (td >= 0 && ty >= 0) break;
        end
        step();
    endtask

    int td, ty;

    initial begin
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd1);
        chk("rst fir_zero_in", 32'(fir_zero_in), 32'd1);
        chk("rst coef_addr", 32'(coef_addr), 32'd0);
        chk("rst coef_wdata", 32'(coef_wdata), 32'd0);
        step();
        rst_n = 1'b1;
        measure(td, ty, 120);
        chk("boot done cycle", td, 46);
        chk("boot y_valid cycle", ty, 55);

        start();
        we_cnt = 0;
        send(N, N - 1, 1'b0);
        measure(td, ty, 120);
        chk("load flush length", td, 46);
        chk("load we pulses", we_cnt, 37);

        start();
        send(N, N - 1, 1'b1);
        measure(td, ty, 120);
        chk("gapped load flush length", td, 46);

        start();
        send(20, 19, 1'b0);
        step();
        chk("early last err", 32'(err), 32'd1);
        chk("early last zero_in", 32'(fir_zero_in), 32'd1);
        chk("early last busy", 32'(busy), 32'd0);
        repeat (60) step();

        start();
        send(N, -1, 1'b0);
        step();
        chk("missing last err", 32'(err), 32'd1);

        start();
        send(N, N - 1, 1'b0);
        measure(td, ty, 120);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        step();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("restart y_valid", 32'(y_valid), 32'd0);
        chk("restart cfg_ready", 32'(cfg_ready), 32'd1);
        chk("restart busy", 32'(busy), 32'd1);
        step();

        send(10, -1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midload rst coef_we", 32'(coef_we), 32'd0);
        chk("midload rst cfg_ready", 32'(cfg_ready), 32'd0);
        chk("midload rst busy", 32'(busy), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        we_cnt = 0;
        measure(td, ty, 120);
        chk("post rst flush length", td, 46);
        chk("post rst we pulses", we_cnt, 0);

        start();
        send(5, -1, 1'b0);
        repeat (1030) step();
`ifdef FIR_CTRL_TIMEOUT_EN
        chk("timeout err", 32'(err), 32'd1);
        chk("timeout cfg_ready", 32'(cfg_ready), 32'd0);
`else
        chk("no timeout cfg_ready", 32'(cfg_ready), 32'd1);
        chk("no timeout err", 32'(err), 32'd0);
`endif
        send(1, 0, 1'b0);

        repeat (6) begin
            start();
            send(N, N - 1, 1'b1);
            repeat (70) begin
                cfg_start = ($urandom_range(0, 24) == 0);
                cfg_valid = $urandom_range(0, 1) == 1;
                cfg_last  = ($urandom_range(0, 29) == 0);
                cfg_data  = CWD'($urandom);
                step();
            end
            cfg_start = 1'b0;
            cfg_valid = 1'b0;
            cfg_last  = 1'b0;
            repeat (60) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
